// File: rtl/ex_pkg.sv
// Shared types and encodings for the execute stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// The tag field is sized for the widest tag the stage supports; ex_stage
// zero-extends its TAG_W-bit tag into it, so TAG_W must be <= EX_TAG_MAX_W.
package ex_pkg;

  localparam int EX_TAG_MAX_W = 16;

  localparam logic UNIT_ALU   = 1'b0;
  localparam logic UNIT_SHIFT = 1'b1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef struct packed {
    logic                    unit;
    logic                    invert_a;
    logic                    invert_b;
    logic [1:0]              operation;
    logic                    left_right;
    logic [4:0]              shamt;
    logic [31:0]             src1;
    logic [31:0]             src2;
    logic [EX_TAG_MAX_W-1:0] tag;
  } ex_req_t;

  typedef struct packed {
    logic [31:0]             result;
    logic                    zero;
    logic                    overflow;
    logic [EX_TAG_MAX_W-1:0] tag;
  } ex_rsp_t;

endpackage

// File: rtl/ALU.sv
// 32-bit combinational ALU: AND / OR / ADD / SLT with optional operand inversion.
// Latency: combinational.
// Backpressure: none.
//
// Ports: aluSrc1/aluSrc2 operands, invertA/invertB invert the operands
// (invertB also supplies the adder carry-in so invertB+ADD is a subtract),
// operation selects the function, result/zero/overflow are the outputs.
// overflow is only meaningful for ADD and reads 0 for the other functions.
module ALU (
  input  logic [31:0] aluSrc1,
  input  logic [31:0] aluSrc2,
  input  logic        invertA,
  input  logic        invertB,
  input  logic [1:0]  operation,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] sum;
  logic        add_ovf;

  assign a   = invertA ? ~aluSrc1 : aluSrc1;
  assign b   = invertB ? ~aluSrc2 : aluSrc2;
  assign sum = a + b + {31'b0, invertB};

  // A carry-in can never push operands of opposite sign out of range, so
  // the usual same-sign test covers the subtract case too.
  assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);

  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (operation)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: begin
        result   = sum;
        overflow = add_ovf;
      end
      default: result = {31'b0, sum[31] ^ add_ovf};
    endcase
  end

  assign zero = (result == 32'h0);

endmodule

// File: rtl/Shifter.sv
// 32-bit combinational logical shifter.
// Latency: combinational.
// Backpressure: none.
//
// Ports: leftRight (1 = left, 0 = right, both logical), shamt shift amount,
// sftSrc operand, result shifted value.
module Shifter (
  input  logic        leftRight,
  input  logic [4:0]  shamt,
  input  logic [31:0] sftSrc,
  output logic [31:0] result
);

  assign result = leftRight ? (sftSrc << shamt) : (sftSrc >> shamt);

endmodule

// File: rtl/ex_result_fifo.sv
// Synchronous result FIFO of ex_rsp_t with a sticky head.
// Latency: push visible at head one edge later; pop takes effect at the edge.
// Backpressure: push ignored when full (without a pop), pop ignored when empty.
//
// Ports: clk/rst (async active-high), push_i/push_dat_i write side,
// pop_i read side, head_o oldest entry, count_o occupancy.
// When empty, head_o keeps showing the most recently held head value so
// downstream outputs do not flicker; reset clears it to zero.
module ex_result_fifo
  import ex_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  ex_rsp_t          push_dat_i,
  input  logic             pop_i,
  output ex_rsp_t          head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ex_rsp_t          mem_q [DEPTH];
  ex_rsp_t          last_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_eff;
  logic             pop_eff;
  logic             not_empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // DEPTH need not be a power of two, so wrap explicitly.
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign not_empty = (count_q != '0);
  assign pop_eff   = pop_i && not_empty;
  assign push_eff  = push_i && ((count_q != CNT_W'(DEPTH)) || pop_eff);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_eff) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop_eff) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_eff, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_eff) begin
        mem_q[wr_ptr_q] <= push_dat_i;
      end
      if (not_empty) begin
        last_q <= mem_q[rd_ptr_q];
      end
    end
  end

  assign head_o  = not_empty ? mem_q[rd_ptr_q] : last_q;
  assign count_o = count_q;

endmodule

// File: rtl/ex_stage.sv
// Registered execute stage: issue register -> ALU/Shifter -> result FIFO.
// Latency: accept at edge N, result at FIFO head after edge N+1.
// Backpressure: in_ready = (issue entry + FIFO count) < FIFO_DEPTH, registered state only.
//
// Ports: in_* request with valid/ready, out_* result with valid/ready,
// done_cnt counts output handshakes (wraps at 16 bits).
// The issue register always drains into the FIFO on the next edge; counting
// it in the occupancy is what keeps that unconditional push from overflowing.
module ex_stage
  import ex_pkg::*;
#(
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_unit,
  input  logic             in_invertA,
  input  logic             in_invertB,
  input  logic [1:0]       in_operation,
  input  logic             in_leftRight,
  input  logic [4:0]       in_shamt,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      done_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  ex_req_t                 req_q, req_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [15:0]             done_cnt_q, done_cnt_d;
  logic [EX_TAG_MAX_W-1:0] tag_ext;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W:0]          occ;
  logic                    accept;
  logic                    pop;
  ex_rsp_t                 rsp;
  ex_rsp_t                 head;
  logic [31:0]             alu_result;
  logic                    alu_zero;
  logic                    alu_overflow;
  logic [31:0]             sft_result;
  logic                    unused_tag;

  assign occ      = (CNT_W + 1)'(fifo_count) + (CNT_W + 1)'(s1_valid_q);
  assign in_ready = (occ < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_comb begin
    tag_ext              = '0;
    tag_ext[TAG_W-1:0]   = in_tag;
  end

  always_comb begin
    req_d      = req_q;
    s1_valid_d = accept;
    if (accept) begin
      req_d.unit       = in_unit;
      req_d.invert_a   = in_invertA;
      req_d.invert_b   = in_invertB;
      req_d.operation  = in_operation;
      req_d.left_right = in_leftRight;
      req_d.shamt      = in_shamt;
      req_d.src1       = in_src1;
      req_d.src2       = in_src2;
      req_d.tag        = tag_ext;
    end
  end

  assign done_cnt_d = done_cnt_q + 16'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      s1_valid_q <= 1'b0;
      done_cnt_q <= 16'h0;
    end else begin
      req_q      <= req_d;
      s1_valid_q <= s1_valid_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  ALU u_alu (
    .aluSrc1   (req_q.src1),
    .aluSrc2   (req_q.src2),
    .invertA   (req_q.invert_a),
    .invertB   (req_q.invert_b),
    .operation (req_q.operation),
    .result    (alu_result),
    .zero      (alu_zero),
    .overflow  (alu_overflow)
  );

  Shifter u_shifter (
    .leftRight (req_q.left_right),
    .shamt     (req_q.shamt),
    .sftSrc    (req_q.src2),
    .result    (sft_result)
  );

  always_comb begin
    rsp     = '0;
    rsp.tag = req_q.tag;
    if (req_q.unit == UNIT_SHIFT) begin
      rsp.result   = sft_result;
      rsp.zero     = (sft_result == 32'h0);
      rsp.overflow = 1'b0;
    end else begin
      rsp.result   = alu_result;
      rsp.zero     = alu_zero;
      rsp.overflow = alu_overflow;
    end
  end

  ex_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (s1_valid_q),
    .push_dat_i (rsp),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (fifo_count)
  );

  assign out_valid    = (fifo_count != '0);
  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_overflow = head.overflow;
  assign out_tag      = head.tag[TAG_W-1:0];
  assign done_cnt     = done_cnt_q;

  // Tag bits above TAG_W are always zero and never reach a port.
  assign unused_tag = ^head.tag;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam int TW    = 4;
  localparam int DEPTH = 3;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_unit;
  logic          in_invertA;
  logic          in_invertB;
  logic [1:0]    in_operation;
  logic          in_leftRight;
  logic [4:0]    in_shamt;
  logic [31:0]   in_src1;
  logic [31:0]   in_src2;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic          out_zero;
  logic          out_overflow;
  logic [TW-1:0] out_tag;
  logic [15:0]   done_cnt;

  typedef struct {
    logic [31:0]   res;
    logic          z;
    logic          o;
    logic [TW-1:0] tag;
    int            acc;
  } exp_t;

  exp_t        sb[$];
  int          n_assert;
  int          n_fail;
  int          cyc;
  int          pops;
  int          nacc;
  logic [15:0] m_done;

  ex_stage #(.TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_unit      (in_unit),
    .in_invertA   (in_invertA),
    .in_invertB   (in_invertB),
    .in_operation (in_operation),
    .in_leftRight (in_leftRight),
    .in_shamt     (in_shamt),
    .in_src1      (in_src1),
    .in_src2      (in_src2),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_tag      (out_tag),
    .done_cnt     (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: operation semantics as integer arithmetic on the current request.
  function automatic exp_t ref_model();
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    longint      t;
    e.tag = in_tag;
    e.acc = cyc;
    e.o   = 1'b0;
    e.res = 32'h0;
    if (in_unit) begin
      e.res = in_leftRight ? (in_src2 << in_shamt) : (in_src2 >> in_shamt);
    end else begin
      a = in_invertA ? ~in_src1 : in_src1;
      b = in_invertB ? ~in_src2 : in_src2;
      t = longint'($signed(a)) + longint'($signed(b)) + (in_invertB ? 64'sd1 : 64'sd0);
      case (in_operation)
        2'b00: e.res = a & b;
        2'b01: e.res = a | b;
        2'b10: begin
          e.res = t[31:0];
          e.o   = (t > MAXI) || (t < MINI);
        end
        default: e.res = (t < 0) ? 32'd1 : 32'd0;
      endcase
    end
    e.z = (e.res == 32'h0);
    return e;
  endfunction

  // One clock: check handshake-visible state against the model, apply
  // accept/pop to the model, advance past the edge.
  task automatic step();
    bit   acc;
    bit   pp;
    exp_t e;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    chk("in_ready", in_ready, sb.size() < DEPTH);
    chk("out_valid", out_valid, (sb.size() > 0) && (cyc >= sb[0].acc + 2));
    chk("done_cnt", done_cnt, m_done);
    if (pp && sb.size() > 0) begin
      e = sb.pop_front();
      chk("head", {out_result, out_zero, out_overflow, out_tag}, {e.res, e.z, e.o, e.tag});
      m_done++;
      pops++;
    end
    if (acc) begin
      sb.push_back(ref_model());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_req(input logic [TW-1:0] tag);
    in_unit      = 1'($urandom_range(0, 1));
    in_invertA   = 1'($urandom_range(0, 1));
    in_invertB   = 1'($urandom_range(0, 1));
    in_operation = 2'($urandom_range(0, 3));
    in_leftRight = 1'($urandom_range(0, 1));
    in_shamt     = 5'($urandom_range(0, 31));
    in_src1      = pick32();
    in_src2      = pick32();
    in_tag       = tag;
  endtask

  task automatic directed(input string name, input logic unit, input logic ia, input logic ib,
                          input logic [1:0] op, input logic lr, input logic [4:0] sh,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [TW-1:0] tag,
                          input logic [31:0] xr, input logic xz, input logic xo);
    in_unit = unit; in_invertA = ia; in_invertB = ib; in_operation = op;
    in_leftRight = lr; in_shamt = sh; in_src1 = s1; in_src2 = s2; in_tag = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({name, "_valid"}, out_valid, 1'b1);
    chk(name, {out_result, out_zero, out_overflow, out_tag}, {xr, xz, xo, tag});
    step();
  endtask

  initial begin
    n_assert = 0; n_fail = 0; cyc = 0; pops = 0; m_done = 16'h0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    rand_req('0);
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_done_cnt", done_cnt, 16'h0);
    chk("rst_outputs", {out_result, out_zero, out_overflow, out_tag}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream, tags 0..9.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_req(TW'(i));
      in_valid = 1'b1;
      chk("stream_in_ready", in_ready, 1'b1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("stream_done_cnt", done_cnt, 16'd10);

    // Stall: exactly DEPTH accepts, then in_ready drops.
    out_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      rand_req(TW'(i + 3));
      in_valid = 1'b1;
      if (in_ready) nacc++;
      step();
    end
    chk("stall_accepts", nacc, DEPTH);
    chk("stall_in_ready", in_ready, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("drain_done_cnt", done_cnt, 16'd13);
    chk("drain_out_valid", out_valid, 1'b0);

    // Directed operations with hand-computed results.
    directed("add_ovf", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd0, 32'h7FFFFFFF, 32'h1, 4'hA, 32'h80000000, 1'b0, 1'b1);
    directed("sub_zero", 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'd5, 32'd5, 4'h3, 32'h0, 1'b1, 1'b0);
    directed("slt", 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 5'd0, 32'd3, 32'd7, 4'h5, 32'h1, 1'b0, 1'b0);
    directed("shl", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 5'd4, 32'h0, 32'hF, 4'h6, 32'hF0, 1'b0, 1'b0);
    directed("shr", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd31, 32'h0, 32'h7FFFFFFF, 4'h7, 32'h0, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_req(TW'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();

    // Reset with two FIFO entries and a live issue register.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_req(TW'(i + 9));
      in_src1  = 32'h1234_0000;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_done_cnt", done_cnt, 16'h0);
    chk("mid_rst_outputs", {out_result, out_zero, out_overflow, out_tag}, '0);
    sb.delete();
    m_done = 16'h0;
    pops = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    out_ready = 1'b1;
    repeat (5) step();

    // Wrap done_cnt: 65536 handshakes -> 0, one more -> 1.
    nacc = 0;
    for (int i = 0; i < 70000 && pops < 65537; i++) begin
      rand_req(TW'(i));
      in_valid = (nacc < 65537);
      if (in_valid && in_ready) nacc++;
      step();
      if (pops == 65536 && out_valid == 1'b1 && nacc == 65537 && sb.size() == 1) begin
        chk("wrap_zero", done_cnt, 16'h0000);
      end
    end
    in_valid = 1'b0;
    chk("wrap_handshakes", pops, 65537);
    chk("wrap_one", done_cnt, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Registered execute stage that sits directly upstream of the combinational `ALU` and `Shifter` and owns their operands and results. It accepts one operation per cycle over a valid/ready handshake, latches operands into an issue register, and drives the ALU or the Shifter. It captures the result and flags into a small output FIFO and presents them downstream over a second valid/ready handshake. This gives the datapath a clean, back-pressurable 2-cycle execute slot.

## Interface
- `TAG_W`, default 4: width of the opaque request tag carried with each operation.
- `FIFO_DEPTH`, default 3: output FIFO entries. Legal values are ≥2. A value ≥3 is required for one op per cycle.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept the request this cycle.
- `in_unit`  in  1  0 = ALU, 1 = Shifter.
- `in_invertA`, `in_invertB`  in  1 each  forwarded to ALU `invertA`/`invertB`.
- `in_operation`  in  2  ALU operation: 00 AND, 01 OR, 10 ADD, 11 SLT.
- `in_leftRight`  in  1  forwarded to Shifter `leftRight`: 1 = left logical, 0 = right logical.
- `in_shamt`  in  5  Shifter shift amount.
- `in_src1`, `in_src2`  in  32 each  ALU `aluSrc1`/`aluSrc2`. `in_src2` is also the Shifter `sftSrc`.
- `in_tag`  in  TAG_W  returned unchanged with the result.
- `out_valid`  out  1  result at FIFO head.
- `out_ready`  in  1  consumer takes the head this cycle.
- `out_result`  out  32  result word.
- `out_zero`, `out_overflow`  out  1 each  result flags.
- `out_tag`  out  TAG_W  tag of the head entry.
- `done_cnt`  out  16  number of completed output handshakes; wraps modulo 2^16.

## Operation
- **Accept:** a request is accepted when `in_valid && in_ready` at a rising edge. Its fields are latched into the issue register and `s1_valid` is set.
- **Execute:** when `s1_valid` is set, the issue register drives `ALU` and `Shifter` combinationally. On the next edge the selected unit's result is pushed into the FIFO and `s1_valid` clears, unless a new accept reloads it in the same edge.
- **Flags, ALU:** `zero` and `overflow` are taken directly from the ALU.
- **Flags, Shifter:** `out_zero = (result == 0)` and `out_overflow = 0`.
- **Inactive unit:** the unselected unit's outputs are ignored.
- **Occupancy:** `occ = s1_valid + fifo_count`. `in_ready = (occ < FIFO_DEPTH)`.
  - `in_ready` is a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.
  - Because `in_ready` counts the in-flight issue-register entry, the FIFO never overflows.
- **Pop:** on `out_valid && out_ready`, the head is popped and `done_cnt` increments by 1, wrapping 0xFFFF→0x0000.
- **Simultaneous push and pop:** allowed in the same edge. The count is unchanged and ordering is preserved.
- **Empty FIFO:** `out_valid = 0`, and `out_result`/flags/tag hold their last values. Consumers must not sample them.
- **Full FIFO:** when `occ == FIFO_DEPTH`, `in_ready = 0`. The stage holds all state until a pop.
- **Ordering:** strict FIFO order; results are returned in request order.
- **Reset:** asserting `rst` at any time, including mid-operation, immediately does the following:
  - clears `s1_valid`, the FIFO pointers/count and `done_cnt`;
  - sets `out_valid = 0`, `out_result = 0`, `out_zero = 0`, `out_overflow = 0`, `out_tag = 0`, `done_cnt = 0`;
  - sets `in_ready = 1`.
  
  In-flight operations are discarded.

## Timing
- **Latency:** accept at edge N → `out_valid` = 1 after edge N+1, provided the FIFO was empty. The result is consumable at edge N+2.
- **Throughput:** one op per cycle in steady state when `out_ready` is held at 1 and `FIFO_DEPTH ≥ 3`.
- **FIFO outputs:** FIFO head outputs come from registers/RAM read with no combinational dependence on `in_*`.
- **Critical path:** the issue register, through the ALU/Shifter, to the FIFO write port. This is one full cycle.

## Structure
- **Package `ex_pkg`:**
  - `UNIT_ALU`/`UNIT_SHIFT` constants;
  - `OP_AND`/`OP_OR`/`OP_ADD`/`OP_SLT` encodings;
  - `ex_req_t`, a packed request struct;
  - `ex_rsp_t`, a packed struct {result, zero, overflow, tag}.
- **Sub-module `ex_result_fifo`:** a parameterised synchronous FIFO of `ex_rsp_t`. It has push/pop/count ports and the same `clk`/`rst`.
- **Top level:** `ex_stage` instantiates the existing `ALU` and `Shifter` unmodified.

## Test plan
- **ALU ADD overflow:** ALU ADD, src1=0x7FFFFFFF, src2=0x00000001, `out_ready` = 1 → `out_valid` 2 edges later, result 0x80000000, overflow = 1, zero = 0, tag echoed.
- **ALU SUB to zero:** ALU SUB (invertB = 1, op = 10), src1 = src2 = 5 → result 0, zero = 1, overflow = 0. Then SLT with 3 vs 7 → result 1.
- **Shifter round trip:** Shifter left, shamt 4, src2=0x0000000F → 0x000000F0, zero = 0. Then right, shamt 31, src2=0x7FFFFFFF → 0, zero = 1, overflow = 0.
- **Streaming with full stall:**
  - Stream 10 back-to-back requests with tags 0..9 and `out_ready` = 1 → `in_ready` stays 1 throughout, outputs appear in tag order, and `done_cnt` = 10.
  - Then hold `out_ready` = 0 → exactly `FIFO_DEPTH` further accepts occur, after which `in_ready` = 0 with no loss.
  - Releasing `out_ready` drains all entries in order.
- **Reset mid-stream:** assert `rst` with 2 entries in the FIFO and `s1_valid` = 1 → outputs immediately go to their reset values (`out_valid` = 0, `in_ready` = 1, `done_cnt` = 0). No stale result appears after `rst` is released.
- **Counter wrap:** preload by running 65 536 handshakes → `done_cnt` wraps to 0x0000 and the next handshake gives 0x0001.
